// File: rtl/pic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pic_pkg                                                       |
// | Description : Shared types, constants and helpers for the PIC ISR block.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package pic_pkg;

    localparam int LEVEL_W    = 3;
    localparam int NUM_LEVELS = 8;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK2 = 1'b1
    } state_t;

    function automatic logic [NUM_LEVELS-1:0] level_onehot(input logic [LEVEL_W-1:0] level);
        return NUM_LEVELS'(1) << level;
    endfunction

    // Position in the rotating order; 0 is the highest priority.
    function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] level,
                                                     input logic [LEVEL_W-1:0] lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pic_priority_resolver                                         |
// | Description : Rotating find-first-set over an 8-level request vector.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] vec,
    input  logic [LEVEL_W-1:0]    lowest_priority,
    output logic [LEVEL_W-1:0]    level,
    output logic                  valid
);

    logic [NUM_LEVELS-1:0] w_rotated;
    logic [LEVEL_W-1:0]    w_offset;

    // Bit 0 of the rotated vector is the current highest-priority level.
    always_comb begin
        w_rotated = '0;
        w_offset  = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            w_rotated[i] = vec[3'(i) + lowest_priority + 3'd1];
        end
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (w_rotated[i]) begin
                w_offset = 3'(i);
            end
        end
    end

    assign level = w_offset + lowest_priority + 3'd1;
    assign valid = |vec;

endmodule : pic_priority_resolver
`default_nettype wire

// File: rtl/pic_priority_isr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pic_priority_isr                                              |
// | Description : Priority resolver, in-service register and INTA sequencer.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module pic_priority_isr
    import pic_pkg::*;
#(
    parameter int VECTOR_BASE_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               irr,
    input  logic                     inta_pulse,
    input  logic                     aeoi,
    input  logic [VECTOR_BASE_W-1:0] vector_base,
    input  logic                     eoi_nonspecific,
    input  logic                     eoi_specific,
    input  logic                     rotate,
    input  logic                     set_priority,
    input  logic [2:0]               cmd_level,
    output logic                     int_req,
    output logic [7:0]               isr,
    output logic                     freeze,
    output logic [7:0]               clear_interrupt_request,
    output logic [7:0]               vector,
    output logic                     vector_valid,
    output logic [2:0]               lowest_priority
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_first_ack;
    logic                 w_second_ack;

    logic [7:0]           r_isr;
    logic [LEVEL_W-1:0]   r_lowest;
    logic [LEVEL_W-1:0]   r_ack_level;
    logic                 r_spurious;
    logic                 r_int_req;
    logic [7:0]           r_clear;
    logic [7:0]           r_vector;
    logic                 r_vector_valid;

    logic [LEVEL_W-1:0]   w_req_level;
    logic                 w_req_valid;
    logic [LEVEL_W-1:0]   w_isr_level;
    logic                 w_isr_valid;
    logic                 w_irq_cond;
    logic [7:0]           w_set_mask;
    logic [7:0]           w_clr_mask;
    logic [LEVEL_W-1:0]   w_lowest_next;

    pic_priority_resolver u_req_resolver (
        .vec             (irr),
        .lowest_priority (r_lowest),
        .level           (w_req_level),
        .valid           (w_req_valid)
    );

    pic_priority_resolver u_isr_resolver (
        .vec             (r_isr),
        .lowest_priority (r_lowest),
        .level           (w_isr_level),
        .valid           (w_isr_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_first_ack  = 1'b0;
        w_second_ack = 1'b0;
        case (r_state)
            ST_IDLE: if (inta_pulse) begin
                w_first_ack  = 1'b1;
                w_state_next = ST_ACK2;
            end
            ST_ACK2: if (inta_pulse) begin
                w_second_ack = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_irq_cond = w_req_valid &&
                        (!w_isr_valid ||
                         (prio_rank(w_req_level, r_lowest) < prio_rank(w_isr_level, r_lowest)));

    // OCW2 commands are evaluated after AEOI so a command's rotate overrides it.
    always_comb begin
        w_set_mask    = (w_first_ack && w_req_valid) ? level_onehot(w_req_level) : 8'h00;
        w_clr_mask    = 8'h00;
        w_lowest_next = r_lowest;
        if (w_second_ack && aeoi && !r_spurious) begin
            w_clr_mask = level_onehot(r_ack_level);
            if (rotate) begin
                w_lowest_next = r_ack_level;
            end
        end
        if (eoi_specific) begin
            w_clr_mask = w_clr_mask | level_onehot(cmd_level);
            if (rotate) begin
                w_lowest_next = cmd_level;
            end
        end else if (eoi_nonspecific) begin
            if (w_isr_valid) begin
                w_clr_mask = w_clr_mask | level_onehot(w_isr_level);
                if (rotate) begin
                    w_lowest_next = w_isr_level;
                end
            end
        end else if (set_priority) begin
            w_lowest_next = cmd_level;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_isr          <= 8'h00;
            r_lowest       <= 3'd7;
            r_ack_level    <= '0;
            r_spurious     <= 1'b0;
            r_int_req      <= 1'b0;
            r_clear        <= 8'h00;
            r_vector       <= 8'h00;
            r_vector_valid <= 1'b0;
        end else begin
            r_isr          <= (r_isr & ~w_clr_mask) | w_set_mask;
            r_lowest       <= w_lowest_next;
            r_int_req      <= w_irq_cond && (w_state_next == ST_IDLE);
            r_clear        <= w_set_mask;
            r_vector_valid <= w_second_ack;
            if (w_first_ack) begin
                r_ack_level <= w_req_valid ? w_req_level : SPURIOUS_LEVEL;
                r_spurious  <= !w_req_valid;
            end
            if (w_second_ack) begin
                r_vector <= {vector_base, r_ack_level};
            end
        end
    end

    assign int_req                 = r_int_req;
    assign isr                     = r_isr;
    assign freeze                  = (r_state == ST_ACK2);
    assign clear_interrupt_request = r_clear;
    assign vector                  = r_vector;
    assign vector_valid            = r_vector_valid;
    assign lowest_priority         = r_lowest;

endmodule : pic_priority_isr
`default_nettype wire

// File: doc/pic_priority_isr.md
# pic_priority_isr

Priority resolver, In-Service Register (ISR) and INTA sequencer for the 8259-compatible PIC. Sits directly downstream of the interrupt request register.
- Consumes the masked request vector `irr`.
- Raises `int_req` toward the CPU.
- Runs the two-pulse INTA sequence (8086 mode), returning the one-hot clear to the request register.
- Tracks in-service levels.
- Applies EOI and rotation commands decoded by control logic.

## Interface
Parameters:
- `VECTOR_BASE_W`, 5, width of the vector base (T7..T3).

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `irr` in 8: masked pending requests from the request register.
- `inta_pulse` in 1: one-clk pulse per CPU INTA cycle (synchronised by control logic).
- `aeoi` in 1: automatic-EOI mode.
- `vector_base` in VECTOR_BASE_W: ICW2 T7..T3.
- `eoi_nonspecific` in 1: one-clk command pulse.
- `eoi_specific` in 1: one-clk command pulse, using `cmd_level`.
- `rotate` in 1: qualifies an EOI pulse as rotate-on-EOI.
- `set_priority` in 1: one-clk pulse; lowest priority becomes `cmd_level`.
- `cmd_level` in 3: level operand for OCW2 commands.
- `int_req` out 1: INT to CPU.
- `isr` out 8: in-service register.
- `freeze` out 1: holds request register contents during the INTA sequence.
- `clear_interrupt_request` out 8: one-hot, one-clk pulse to the request register.
- `vector` out 8: interrupt vector, `{vector_base, level}`.
- `vector_valid` out 1: one-clk pulse, qualifies `vector`.
- `lowest_priority` out 3: current lowest-priority level.

## Operation
Reset values:
- `isr` = 0, `lowest_priority` = 7 (IR0 highest).
- FSM = IDLE.
- `int_req`, `freeze`, `vector_valid` = 0.
- `clear_interrupt_request` = 0, `vector` = 0.

Priority resolution:
- Order starts at level (`lowest_priority`+1) mod 8, ascending with wrap; `lowest_priority` is last.
- `req_level` = highest-priority set bit of `irr`; `isr_level` = highest-priority set bit of `isr`.
- `int_req` condition: `irr` ≠ 0 and (`isr` = 0 or `req_level` strictly higher priority than `isr_level`). This is fully nested mode.

FSM:
- IDLE, on `inta_pulse`:
  - If `irr` ≠ 0: latch `req_level` into `ack_level`, set `isr[ack_level]`, pulse `clear_interrupt_request[ack_level]`, assert `freeze`, go to ACK2.
  - If `irr` = 0 (spurious): `ack_level` = 7, `isr` unchanged, no clear pulse, assert `freeze`, go to ACK2.
- ACK2, on `inta_pulse`:
  - Drive `vector` = {`vector_base`, `ack_level`} and pulse `vector_valid`.
  - If `aeoi` and not spurious: clear `isr[ack_level]`; if `rotate` is also set, `lowest_priority` ← `ack_level`.
  - Deassert `freeze`, go to IDLE.
- `int_req` is forced 0 while in ACK2.

Commands (accepted in any state):
- `eoi_nonspecific`: clear the bit at `isr_level`. No-op if `isr` = 0. With `rotate`, `lowest_priority` ← cleared level.
- `eoi_specific`: clear `isr[cmd_level]`. With `rotate`, `lowest_priority` ← `cmd_level`.
- `set_priority`: `lowest_priority` ← `cmd_level`.
- More than one command pulse in the same cycle: priority is `eoi_specific` > `eoi_nonspecific` > `set_priority`.

Simultaneous events:
- ISR next = (`isr` & ~eoi_clear) | inta_set. If the same bit is both cleared and set, the set wins.
- A rotate from EOI and a rotate from AEOI in the same cycle: the EOI rotate wins.
- `reset` mid-sequence (either state) returns to IDLE: `isr` cleared, `freeze` dropped, no `vector_valid`.

## Timing
- `int_req` is registered: it reflects `irr`/`isr` from the previous cycle (1-clk latency).
- `clear_interrupt_request` and ISR set occur on the edge that samples the first `inta_pulse`.
- `freeze` is high from the cycle after the first `inta_pulse` through the cycle the second `inta_pulse` is sampled, then low.
- `vector`/`vector_valid` are registered, valid the cycle after the second `inta_pulse` is sampled. `vector` holds its value until the next ACK2.
- An `inta_pulse` arriving while `freeze` is already deasserting is taken as a new first pulse. No pulse is ever lost.

## Structure
- Shared package `pic_pkg` holds:
  - FSM state encoding (`ST_IDLE`, `ST_ACK2`)
  - `SPURIOUS_LEVEL` = 7
  - level width constant = 3
- Sub-module `pic_priority_resolver` is combinational: rotate the vector by `lowest_priority`+1, find-first-set, un-rotate, output level plus valid. It is instantiated twice, once for `irr` and once for `isr`.

## Test plan
- Basic ack: reset, `irr`=0x24, `vector_base`=0x08, two INTA pulses.
  - `int_req`=1.
  - First pulse → `clear_interrupt_request`=0x04, `isr`=0x04.
  - Second pulse → `vector`=0x42, `vector_valid` for 1 clk.
- Nesting: `isr`=0x04.
  - `irr`=0x08 → `int_req` stays 0.
  - `irr`=0x01 → `int_req`=1.
  - Then `eoi_nonspecific` → `isr` bit 0 clears first, and bit 2 is retained.
- Spurious: first INTA with `irr`=0 → no clear pulse, `isr` unchanged, `vector`=0x47.
- Rotation: `isr`=0x08, `eoi_nonspecific`+`rotate` → `isr`=0, `lowest_priority`=3. Then `irr`=0x11 → ack selects level 4.
- AEOI + collision: `aeoi`=1, ack IR5 → `isr` returns to 0 after the second pulse. `eoi_specific` level 5 in the same cycle as a first INTA for IR5 → `isr[5]`=1.
- Reset in ACK2 → `freeze`=0, `isr`=0, no `vector_valid` on a following INTA pulse. That pulse is treated as a new first pulse.
